fwpayload_wb_master: RTL and testbench

Wishbone classic (B3) initiator that carries the fwrisc core's data-side valid/ready bus out to a Wishbone slave. It lets the core reach peripherals and storage that live behind a Wishbone responder, including the payload's own WB storage bridge. The block sits between the core's d* port and the payload-level Wishbone interconnect. It adds a bus-error path and a no-ack timeout so a missing slave cannot hang the core.

---
 rtl/fwpayload_wb_master.sv | 179 +++++++++++++++++
 tb/tb_fwpayload_wb_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwpayload_wb_master.sv
// fwpayload_wb_master: bridges the fwrisc core's data-side valid/ready bus to
// a Wishbone classic (B3) slave. Single outstanding transfer, with a bus-error
// path and a no-ack timeout so an absent slave cannot stall the core.
module fwpayload_wb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dvalid,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwstb,
   input  logic        dwrite,
   output logic [31:0] drdata,
   output logic        dready,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        bus_err_o,
   input  logic        err_clr_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;

   logic        r_cyc;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [31:0] r_drdata;
   logic        r_dready;
   logic        r_bus_err;
   logic [31:0] r_cnt;

   logic        w_cyc_nx;
   logic        w_we_nx;
   logic [3:0]  w_sel_nx;
   logic [31:0] w_adr_nx;
   logic [31:0] w_dat_nx;
   logic [31:0] w_drdata_nx;
   logic        w_dready_nx;
   logic        w_bus_err_nx;
   logic        w_err_set;
   logic [31:0] w_cnt_nx;
   logic        w_timeout;

   // The timeout fires on the last permitted BUS cycle; zero disables it.
   assign w_timeout = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == (TIMEOUT_CYCLES - 32'd1));

   // Next-state and next-output computation; everything holds unless a rule below changes it.
   always_comb begin
      w_state_nx  = r_state;
      w_cyc_nx    = r_cyc;
      w_we_nx     = r_we;
      w_sel_nx    = r_sel;
      w_adr_nx    = r_adr;
      w_dat_nx    = r_dat;
      w_drdata_nx = r_drdata;
      w_dready_nx = 1'b0;
      w_cnt_nx    = r_cnt;
      w_err_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dvalid) begin
               // Latch the whole request so later changes on the core side are ignored.
               w_state_nx = ST_BUS;
               w_cyc_nx   = 1'b1;
               w_we_nx    = dwrite;
               w_sel_nx   = dwrite ? dwstb : 4'hF;
               w_adr_nx   = daddr & 32'hFFFF_FFFC;
               w_dat_nx   = dwdata;
               w_cnt_nx   = 32'd0;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_BUS: begin
            w_cnt_nx = r_cnt + 32'd1;
            if (wbm_err_i || (!wbm_ack_i && w_timeout)) begin
               // Error beats a same-cycle ack; an ack beats a same-cycle timeout.
               w_state_nx  = ST_RESP;
               w_cyc_nx    = 1'b0;
               w_we_nx     = 1'b0;
               w_drdata_nx = ERR_RDATA;
               w_dready_nx = 1'b1;
               w_cnt_nx    = 32'd0;
               w_err_set   = 1'b1;
            end else if (wbm_ack_i) begin
               w_state_nx  = ST_RESP;
               w_cyc_nx    = 1'b0;
               w_we_nx     = 1'b0;
               w_drdata_nx = r_we ? 32'h0000_0000 : wbm_dat_i;
               w_dready_nx = 1'b1;
               w_cnt_nx    = 32'd0;
            end else begin
               w_state_nx = ST_BUS;
            end
         end
         ST_RESP: begin
            // dready is high during this state; the next cycle returns to IDLE.
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cyc_nx   = 1'b0;
            w_we_nx    = 1'b0;
            w_cnt_nx   = 32'd0;
         end
      endcase

      // Sticky error flag: a set in the same cycle wins over a clear.
      if (w_err_set) begin
         w_bus_err_nx = 1'b1;
      end else if (err_clr_i) begin
         w_bus_err_nx = 1'b0;
      end else begin
         w_bus_err_nx = r_bus_err;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Output and datapath registers; reset aborts any transfer without a dready pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= 4'h0;
         r_adr     <= 32'h0000_0000;
         r_dat     <= 32'h0000_0000;
         r_drdata  <= 32'h0000_0000;
         r_dready  <= 1'b0;
         r_bus_err <= 1'b0;
         r_cnt     <= 32'd0;
      end else begin
         r_cyc     <= w_cyc_nx;
         r_we      <= w_we_nx;
         r_sel     <= w_sel_nx;
         r_adr     <= w_adr_nx;
         r_dat     <= w_dat_nx;
         r_drdata  <= w_drdata_nx;
         r_dready  <= w_dready_nx;
         r_bus_err <= w_bus_err_nx;
         r_cnt     <= w_cnt_nx;
      end
   end

   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;
   assign drdata    = r_drdata;
   assign dready    = r_dready;
   assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_fwpayload_wb_master.sv
// Testbench for fwpayload_wb_master: directed stimulus, a transaction-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_fwpayload_wb_master;

   localparam int unsigned TO  = 4;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clock = 1'b0;
   logic        reset;
   logic        dvalid;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwstb;
   logic        dwrite;
   logic [31:0] drdata;
   logic        dready;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;
   logic        bus_err_o;
   logic        err_clr_i;

   int checks   = 0;
   int failures = 0;

   fwpayload_wb_master #(
      .TIMEOUT_CYCLES(TO),
      .ERR_RDATA     (ERR)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .dvalid   (dvalid),
      .daddr    (daddr),
      .dwdata   (dwdata),
      .dwstb    (dwstb),
      .dwrite   (dwrite),
      .drdata   (drdata),
      .dready   (dready),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i),
      .bus_err_o(bus_err_o),
      .err_clr_i(err_clr_i)
   );

   always #5 clock = ~clock;

   // ---------------- reference model (transaction level) ----------------
   // One transfer at a time: "busy" while it is on the bus, "age" = cycles
   // it has spent there. A completion produces one response cycle, during
   // which the block ignores new requests.
   logic        m_ok = 1'b0;
   logic        m_busy;
   int unsigned m_age;
   logic        e_we;
   logic [3:0]  e_sel;
   logic [31:0] e_adr, e_dat, e_drdata;
   logic        e_dready, e_bus_err;

   always @(posedge clock) begin
      logic set_err;
      logic done;
      set_err = 1'b0;
      done    = 1'b0;
      if (reset) begin
         m_ok = 1'b1; m_busy = 1'b0; m_age = 0;
         e_we = 1'b0; e_sel = 4'h0; e_adr = 32'h0; e_dat = 32'h0;
         e_drdata = 32'h0; e_dready = 1'b0; e_bus_err = 1'b0;
      end else if (m_ok) begin
         if (m_busy) begin
            m_age = m_age + 1;
            if (wbm_err_i || (!wbm_ack_i && m_age == TO)) begin
               e_drdata = ERR; set_err = 1'b1; done = 1'b1;
            end else if (wbm_ack_i) begin
               e_drdata = e_we ? 32'h0 : wbm_dat_i; done = 1'b1;
            end
            if (done) begin
               m_busy = 1'b0; e_we = 1'b0; e_dready = 1'b1;
            end
         end else if (e_dready) begin
            e_dready = 1'b0;
         end else if (dvalid) begin
            m_busy = 1'b1; m_age = 0;
            e_we  = dwrite;
            e_sel = dwrite ? dwstb : 4'hF;
            e_adr = {daddr[31:2], 2'b00};
            e_dat = dwdata;
         end
         if (set_err) e_bus_err = 1'b1;
         else if (err_clr_i) e_bus_err = 1'b0;
      end
   end

   // Compare DUT outputs with the model on every falling edge.
   always @(negedge clock) begin
      if (m_ok) begin
         checks = checks + 1;
         if (wbm_cyc_o !== m_busy || wbm_stb_o !== m_busy || wbm_we_o !== e_we ||
             wbm_sel_o !== e_sel || wbm_adr_o !== e_adr || wbm_dat_o !== e_dat ||
             drdata !== e_drdata || dready !== e_dready || bus_err_o !== e_bus_err) begin
            failures = failures + 1;
            $display("FAIL model t=%0t got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rd=%h rdy=%b err=%b exp cyc=%b we=%b sel=%h adr=%h dat=%h rd=%h rdy=%b err=%b",
                     $time, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                     drdata, dready, bus_err_o, m_busy, e_we, e_sel, e_adr, e_dat, e_drdata,
                     e_dready, e_bus_err);
         end
      end
   end

   // ---------------- literal checks ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
      dvalid = 1'b1; daddr = a; dwdata = d; dwstb = s; dwrite = w;
   endtask

   initial begin
      int n_cyc;
      int n_rdy;
      logic [31:0] got_rd;
      reset = 1'b1; dvalid = 1'b0; daddr = 32'h0; dwdata = 32'h0; dwstb = 4'h0;
      dwrite = 1'b0; wbm_dat_i = 32'h0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr_i = 1'b0;
      tick(); tick();
      chk("reset_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      chk("reset_drdata", drdata, 32'h0);
      reset = 1'b0;
      tick();

      // 1: zero-wait read
      req(32'h80000010, 32'h0, 4'h0, 1'b0);
      tick();
      chk("rd_cyc_T1", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
      chk("rd_adr", wbm_adr_o, 32'h80000010);
      chk("rd_sel_we", {27'd0, wbm_sel_o, wbm_we_o}, {27'd0, 4'hF, 1'b0});
      dvalid = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'h12345678;
      tick();
      wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
      chk("rd_dready_T2", {31'd0, dready}, 32'd1);
      chk("rd_drdata", drdata, 32'h12345678);
      tick();
      chk("rd_dready_1cyc", {31'd0, dready}, 32'd0);
      chk("rd_drdata_hold", drdata, 32'h12345678);

      // 2: write with two wait states; request fields change mid-transfer
      req(32'hC0000006, 32'hA5A5A5A5, 4'b0011, 1'b1);
      tick();
      chk("wr_adr", wbm_adr_o, 32'hC0000004);
      chk("wr_sel", {28'd0, wbm_sel_o}, 32'h3);
      chk("wr_dat", wbm_dat_o, 32'hA5A5A5A5);
      dvalid = 1'b0; daddr = 32'h11111111; dwdata = 32'h0; dwstb = 4'hC;
      tick();
      chk("wr_we_w2", {31'd0, wbm_we_o}, 32'd1);
      chk("wr_adr_held", wbm_adr_o, 32'hC0000004);
      tick();
      chk("wr_we_w3", {31'd0, wbm_we_o}, 32'd1);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      chk("wr_dready", {31'd0, dready}, 32'd1);
      chk("wr_drdata0", drdata, 32'h0);
      chk("wr_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
      tick();

      // 3: ack and err together; sticky flag and set-beats-clear
      req(32'h00000020, 32'h0, 4'h0, 1'b0);
      tick();
      dvalid = 1'b0; wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h0BADF00D;
      tick();
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      chk("err_drdata", drdata, 32'hDEADBEEF);
      chk("err_dready", {31'd0, dready}, 32'd1);
      chk("err_flag", {31'd0, bus_err_o}, 32'd1);
      tick(); tick();
      chk("err_sticky", {31'd0, bus_err_o}, 32'd1);
      req(32'h00000024, 32'h0, 4'h0, 1'b0);
      tick();
      dvalid = 1'b0; wbm_err_i = 1'b1; err_clr_i = 1'b1;
      tick();
      wbm_err_i = 1'b0;
      chk("err_set_wins", {31'd0, bus_err_o}, 32'd1);
      tick();
      err_clr_i = 1'b0;
      chk("err_cleared", {31'd0, bus_err_o}, 32'd0);

      // 4a: timeout, slave never answers
      req(32'h00000100, 32'h0, 4'h0, 1'b0);
      tick();
      dvalid = 1'b0;
      n_cyc = 0; n_rdy = 0; got_rd = 32'h0;
      for (int i = 0; i < 10; i++) begin
         if (wbm_cyc_o) n_cyc++;
         if (dready) begin n_rdy++; got_rd = drdata; end
         tick();
      end
      chk("to_cyc_cycles", n_cyc, 32'd4);
      chk("to_dready_cnt", n_rdy, 32'd1);
      chk("to_drdata", got_rd, 32'hDEADBEEF);
      chk("to_flag", {31'd0, bus_err_o}, 32'd1);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;

      // 4b: ack arrives in the 4th cycle and beats the timeout
      req(32'h00000104, 32'h0, 4'h0, 1'b0);
      tick(); dvalid = 1'b0;
      tick(); tick(); tick();
      chk("to4_cyc_still", {31'd0, wbm_cyc_o}, 32'd1);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h55AA0FF0;
      tick();
      wbm_ack_i = 1'b0;
      chk("to4_drdata", drdata, 32'h55AA0FF0);
      chk("to4_noerr", {31'd0, bus_err_o}, 32'd0);
      tick();

      // 5: back-to-back reads with dvalid held; spurious ack in IDLE
      req(32'h00000200, 32'h0, 4'h0, 1'b0);
      tick();
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000AAAA;
      tick();
      chk("b2b_rd1", drdata, 32'h0000AAAA);
      daddr = 32'h00000300; wbm_ack_i = 1'b0;
      tick();
      chk("b2b_gap", {31'd0, wbm_cyc_o}, 32'd0);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF0000;
      tick();
      wbm_ack_i = 1'b0; dvalid = 1'b0;
      chk("b2b_adr2", wbm_adr_o, 32'h00000300);
      chk("b2b_spur_nordy", {31'd0, dready}, 32'd0);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000BBBB;
      tick();
      wbm_ack_i = 1'b0;
      chk("b2b_rd2", drdata, 32'h0000BBBB);
      tick();
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      chk("idle_spur_ack", {31'd0, dready}, 32'd0);

      // 6: reset during the 2nd wait cycle, then a normal read
      req(32'h00000400, 32'h0, 4'h0, 1'b0);
      tick(); dvalid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      chk("rst_adr", wbm_adr_o, 32'h0);
      n_rdy = 0;
      for (int i = 0; i < 3; i++) begin
         if (dready) n_rdy++;
         tick();
      end
      chk("rst_no_dready", n_rdy, 32'd0);
      req(32'h00000408, 32'h0, 4'h0, 1'b0);
      tick();
      dvalid = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFEF00D;
      tick();
      wbm_ack_i = 1'b0;
      chk("rst_next_rd", drdata, 32'hCAFEF00D);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
